// File: rtl/image_ycbcr444_rgb888.sv
`default_nettype none
// ============================================================================
// Module      : image_ycbcr444_rgb888
// Description : Four-stage YCbCr444 -> RGB888 converter (BT.601 full range,
//               Q8 coefficients) with the frame sync flags delayed to match.
// Revision    : 1.0 - initial release
// ============================================================================
module image_ycbcr444_rgb888 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_Y,
    input  logic [7:0] per_img_Cb,
    input  logic [7:0] per_img_Cr,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_red,
    output logic [7:0] post_img_green,
    output logic [7:0] post_img_blue
);

    localparam logic signed [17:0] c_coef_r_cr = 18'sd359;
    localparam logic signed [17:0] c_coef_g_cb = 18'sd88;
    localparam logic signed [17:0] c_coef_g_cr = 18'sd183;
    localparam logic signed [17:0] c_coef_b_cb = 18'sd454;
    localparam logic signed [18:0] c_round     = 19'sd128;

    // Stage 1: remove chroma offset, scale luma into Q8
    logic signed [8:0]  w_cb_s;
    logic signed [8:0]  w_cr_s;
    logic signed [8:0]  r_cb_s;
    logic signed [8:0]  r_cr_s;
    logic        [16:0] r_y_s1;

    assign w_cb_s = $signed({1'b0, per_img_Cb}) - $signed(9'd128);
    assign w_cr_s = $signed({1'b0, per_img_Cr}) - $signed(9'd128);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cb_s <= '0;
            r_cr_s <= '0;
            r_y_s1 <= '0;
        end else begin
            r_cb_s <= w_cb_s;
            r_cr_s <= w_cr_s;
            r_y_s1 <= {1'b0, per_img_Y, 8'd0};
        end
    end

    // Stage 2: coefficient products
    logic signed [17:0] w_cb_ext;
    logic signed [17:0] w_cr_ext;
    logic signed [17:0] r_p_r_cr;
    logic signed [17:0] r_p_g_cb;
    logic signed [17:0] r_p_g_cr;
    logic signed [17:0] r_p_b_cb;
    logic        [16:0] r_y_s2;

    assign w_cb_ext = {{9{r_cb_s[8]}}, r_cb_s};
    assign w_cr_ext = {{9{r_cr_s[8]}}, r_cr_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_r_cr <= '0;
            r_p_g_cb <= '0;
            r_p_g_cr <= '0;
            r_p_b_cb <= '0;
            r_y_s2   <= '0;
        end else begin
            r_p_r_cr <= w_cr_ext * c_coef_r_cr;
            r_p_g_cb <= w_cb_ext * c_coef_g_cb;
            r_p_g_cr <= w_cr_ext * c_coef_g_cr;
            r_p_b_cb <= w_cb_ext * c_coef_b_cb;
            r_y_s2   <= r_y_s1;
        end
    end

    // Stage 3: sum with +128 so the arithmetic shift rounds half-up
    logic signed [18:0] w_y_ext;
    logic signed [18:0] w_sum_r;
    logic signed [18:0] w_sum_g;
    logic signed [18:0] w_sum_b;
    logic signed [10:0] r_r3;
    logic signed [10:0] r_g3;
    logic signed [10:0] r_b3;

    assign w_y_ext = $signed({2'b00, r_y_s2});
    assign w_sum_r = w_y_ext + {r_p_r_cr[17], r_p_r_cr} + c_round;
    assign w_sum_g = w_y_ext - {r_p_g_cb[17], r_p_g_cb}
                             - {r_p_g_cr[17], r_p_g_cr} + c_round;
    assign w_sum_b = w_y_ext + {r_p_b_cb[17], r_p_b_cb} + c_round;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r3 <= '0;
            r_g3 <= '0;
            r_b3 <= '0;
        end else begin
            r_r3 <= w_sum_r[18:8];
            r_g3 <= w_sum_g[18:8];
            r_b3 <= w_sum_b[18:8];
        end
    end

    // Sync flag delay lines; bit [2] lines up with stage-3 data
    logic [3:0] r_vsync_sr;
    logic [3:0] r_href_sr;
    logic [3:0] r_clken_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_sr <= '0;
            r_href_sr  <= '0;
            r_clken_sr <= '0;
        end else begin
            r_vsync_sr <= {r_vsync_sr[2:0], per_frame_vsync};
            r_href_sr  <= {r_href_sr[2:0],  per_frame_href};
            r_clken_sr <= {r_clken_sr[2:0], per_frame_clken};
        end
    end

    // Stage 4: clamp to 0..255 and blank outside active lines
    function automatic logic [7:0] f_clamp(input logic signed [10:0] v);
        if (v[10])
            return 8'd0;
        else if (v[9:8] != 2'b00)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    logic [7:0] r_red;
    logic [7:0] r_green;
    logic [7:0] r_blue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (r_href_sr[2]) begin
            r_red   <= f_clamp(r_r3);
            r_green <= f_clamp(r_g3);
            r_blue  <= f_clamp(r_b3);
        end else begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end
    end

    assign post_frame_vsync = r_vsync_sr[3];
    assign post_frame_href  = r_href_sr[3];
    assign post_frame_clken = r_clken_sr[3];
    assign post_img_red     = r_red;
    assign post_img_green   = r_green;
    assign post_img_blue    = r_blue;

endmodule
`default_nettype wire

// File: tb/tb_image_ycbcr444_rgb888.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_ycbcr444_rgb888
// Description : Randomized self-checking bench for image_ycbcr444_rgb888
//               against an arithmetic colour-space reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_ycbcr444_rgb888;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vs_i = 1'b0, hs_i = 1'b0, ce_i = 1'b0;
    logic [7:0] y_i = 8'd0, cb_i = 8'd0, cr_i = 8'd0;
    logic       vs_o, hs_o, ce_o;
    logic [7:0] r_o, g_o, b_o;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    image_ycbcr444_rgb888 dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (vs_i),
        .per_frame_href   (hs_i),
        .per_frame_clken  (ce_i),
        .per_img_Y        (y_i),
        .per_img_Cb       (cb_i),
        .per_img_Cr       (cr_i),
        .post_frame_vsync (vs_o),
        .post_frame_href  (hs_o),
        .post_frame_clken (ce_o),
        .post_img_red     (r_o),
        .post_img_green   (g_o),
        .post_img_blue    (b_o)
    );

    // Input history indexed by clock edge: {valid, vs, hs, ce, Y, Cb, Cr}
    logic [27:0] hist [0:32767];
    int cyc = 0;
    int last_rst_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        hist[(cyc + 1) & 32767] <= {rst_n, vs_i, hs_i, ce_i, y_i, cb_i, cr_i};
    end

    always @(negedge rst_n) last_rst_cyc <= cyc;

    function automatic logic [7:0] clamp(input int v);
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    // Expected {vs, hs, ce, R, G, B} visible after edge m
    function automatic logic [26:0] expect_at(input int m);
        logic [27:0] e;
        int k, y, cb, cr, r, g, b;
        k = m - 3;
        if (k < 1 || k <= last_rst_cyc) return '0;
        e = hist[k & 32767];
        if (!e[27]) return '0;
        y  = int'(e[23:16]);
        cb = int'(e[15:8]) - 128;
        cr = int'(e[7:0]) - 128;
        r = (y * 256 + 359 * cr + 128) >>> 8;
        g = (y * 256 - 88 * cb - 183 * cr + 128) >>> 8;
        b = (y * 256 + 454 * cb + 128) >>> 8;
        if (e[25])
            return {e[26:24], clamp(r), clamp(g), clamp(b)};
        return {e[26:24], 24'd0};
    endfunction

    task automatic drive(input logic vs, input logic hs, input logic ce,
                         input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        @(posedge clk);
        #1;
        vs_i = vs; hs_i = hs; ce_i = ce;
        y_i = y; cb_i = cb; cr_i = cr;
    endtask

    task automatic test_reset();
        logic [26:0] got;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
            @(negedge clk);
            got = {vs_o, hs_o, ce_o, r_o, g_o, b_o};
            total++;
            if (got !== 27'd0)
                $display("FAIL reset_state cyc=%0d got=%h required=0", i, got);
            else
                passed++;
        end
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [23:0] vin  [0:3];
        logic [23:0] vexp [0:3];
        logic [26:0] got, ex;
        vin[0] = {8'd128, 8'd128, 8'd128}; vexp[0] = {8'd128, 8'd128, 8'd128};
        vin[1] = {8'd255, 8'd128, 8'd255}; vexp[1] = {8'd255, 8'd164, 8'd255};
        vin[2] = {8'd0,   8'd0,   8'd0};   vexp[2] = {8'd0,   8'd136, 8'd0};
        vin[3] = {8'd76,  8'd85,  8'd255}; vexp[3] = {8'd254, 8'd0,   8'd0};
        for (int i = 0; i < 8; i++) begin
            if (i < 4)
                drive(1'b0, 1'b1, 1'b1, vin[i][23:16], vin[i][15:8], vin[i][7:0]);
            else
                drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
            @(negedge clk);
            got = {vs_o, hs_o, ce_o, r_o, g_o, b_o};
            ex  = expect_at(cyc);
            total++;
            if (got !== ex)
                $display("FAIL directed_model i=%0d got=%h required=%h", i, got, ex);
            else
                passed++;
            if (i >= 4) begin
                total++;
                if ({hs_o, ce_o, r_o, g_o, b_o} !== {2'b11, vexp[i-4]})
                    $display("FAIL directed_vector v=%0d got href=%b clken=%b rgb=%0d/%0d/%0d required 1/1 rgb=%0d/%0d/%0d",
                             i - 4, hs_o, ce_o, r_o, g_o, b_o,
                             vexp[i-4][23:16], vexp[i-4][15:8], vexp[i-4][7:0]);
                else
                    passed++;
            end
        end
    endtask

    task automatic test_framing();
        logic [26:0] got, ex;
        logic vs, hs, ce;
        for (int f = 0; f < 2; f++) begin
            for (int t = 0; t < 7 + 6 * 46; t++) begin
                vs = (t < 3);
                hs = (t >= 7) && (((t - 7) % 46) < 40);
                ce = hs && ($urandom_range(0, 3) != 0);
                drive(vs, hs, ce, 8'($urandom), 8'($urandom), 8'($urandom));
                @(negedge clk);
                got = {vs_o, hs_o, ce_o, r_o, g_o, b_o};
                ex  = expect_at(cyc);
                total++;
                if (got !== ex)
                    $display("FAIL framing f=%0d t=%0d got=%h required=%h", f, t, got, ex);
                else
                    passed++;
                if (!hs_o) begin
                    total++;
                    if ({r_o, g_o, b_o} !== 24'd0)
                        $display("FAIL blank_data f=%0d t=%0d got=%h required=0", f, t, {r_o, g_o, b_o});
                    else
                        passed++;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [26:0] got, ex;
        logic [7:0] y;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       y = 8'd0;
                1:       y = 8'd255;
                default: y = 8'($urandom);
            endcase
            drive(1'b0, 1'b1, 1'b1, y, 8'($urandom), 8'($urandom));
            @(negedge clk);
            got = {vs_o, hs_o, ce_o, r_o, g_o, b_o};
            ex  = expect_at(cyc);
            total++;
            if (got !== ex)
                $display("FAIL back_to_back i=%0d got=%h required=%h", i, got, ex);
            else
                passed++;
        end
    endtask

    task automatic test_reset_mid_line();
        logic [26:0] got, ex;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
            @(negedge clk);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        got = {vs_o, hs_o, ce_o, r_o, g_o, b_o};
        total++;
        if (got !== 27'd0)
            $display("FAIL reset_immediate got=%h required=0", got);
        else
            passed++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
            if (i == 2) rst_n = 1'b1;
            @(negedge clk);
            got = {vs_o, hs_o, ce_o, r_o, g_o, b_o};
            ex  = expect_at(cyc);
            total++;
            if (got !== ex)
                $display("FAIL reset_hold i=%0d got=%h required=%h", i, got, ex);
            else
                passed++;
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
            @(negedge clk);
            got = {vs_o, hs_o, ce_o, r_o, g_o, b_o};
            ex  = expect_at(cyc);
            total++;
            if (got !== ex)
                $display("FAIL reset_release i=%0d got=%h required=%h", i, got, ex);
            else
                passed++;
            if (i < 3) begin
                total++;
                if (hs_o !== 1'b0)
                    $display("FAIL reset_no_href i=%0d got=%b required=0", i, hs_o);
                else
                    passed++;
            end
        end
    endtask

    task automatic test_drain();
        logic [26:0] got, ex;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
            @(negedge clk);
            got = {vs_o, hs_o, ce_o, r_o, g_o, b_o};
            ex  = expect_at(cyc);
            total++;
            if (got !== ex)
                $display("FAIL drain i=%0d got=%h required=%h", i, got, ex);
            else
                passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_framing();
        test_back_to_back();
        test_reset_mid_line();
        test_drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
